// File: rtl/mmu_resp_arbiter.sv
// rtl/mmu_resp_arbiter.sv - round-robin pop of alloc/free result FIFOs into a 2-entry skid response channel
// Optional MMU_RESP_STATS_EN adds saturating 16-bit accept counters per type and outcome.
module mmu_resp_arbiter #(
   parameter int ID_W   = 8,
   parameter int PIDX_W = 10,
   parameter int RSN_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alloc_fifo_empty,
   output logic              alloc_fifo_pop_en,
   input  logic [ID_W-1:0]   alloc_fifo_req_id,
   input  logic [PIDX_W-1:0] alloc_fifo_page_idx,
   input  logic              alloc_fifo_fail,
   input  logic [RSN_W-1:0]  alloc_fifo_reason,
   input  logic              free_fifo_empty,
   output logic              free_fifo_pop_en,
   input  logic [ID_W-1:0]   free_fifo_req_id,
   input  logic              free_fifo_fail,
   input  logic [RSN_W-1:0]  free_fifo_reason,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_type,
   output logic [ID_W-1:0]   resp_req_id,
   output logic [PIDX_W-1:0] resp_page_idx,
   output logic              resp_fail,
   output logic [RSN_W-1:0]  resp_reason
`ifdef MMU_RESP_STATS_EN
   ,
   output logic [15:0]       stat_alloc_ok,
   output logic [15:0]       stat_alloc_fail,
   output logic [15:0]       stat_free_ok,
   output logic [15:0]       stat_free_fail
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic              typ;
      logic [ID_W-1:0]   id;
      logic [PIDX_W-1:0] idx;
      logic              fail;
      logic [RSN_W-1:0]  reason;
   } entry_t;

   state_t state_q, state_d;
   entry_t out_q, out_d;
   entry_t skid_q, skid_d;
   entry_t new_e;
   logic   rr_last_q, rr_last_d;
   logic   eligible;
   logic   take;
   logic   acc;

   // Popping is also held off while reset is asserted, not just while FULL.
   assign eligible          = rst_n && (state_q != ST_FULL);
   assign alloc_fifo_pop_en = eligible && !alloc_fifo_empty && (free_fifo_empty || rr_last_q);
   assign free_fifo_pop_en  = eligible && !free_fifo_empty && (alloc_fifo_empty || !rr_last_q);
   assign take              = alloc_fifo_pop_en || free_fifo_pop_en;
   assign acc               = resp_valid && resp_ready;

   always_comb begin
      new_e        = '0;
      new_e.typ    = free_fifo_pop_en;
      if (free_fifo_pop_en) begin
         new_e.id     = free_fifo_req_id;
         new_e.fail   = free_fifo_fail;
         new_e.reason = free_fifo_fail ? free_fifo_reason : '0;
      end else begin
         new_e.id     = alloc_fifo_req_id;
         new_e.idx    = alloc_fifo_page_idx;
         new_e.fail   = alloc_fifo_fail;
         new_e.reason = alloc_fifo_fail ? alloc_fifo_reason : '0;
      end
   end

   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      skid_d    = skid_q;
      rr_last_d = rr_last_q;
      if (take) begin
         rr_last_d = free_fifo_pop_en;
      end
      case (state_q)
         ST_EMPTY: begin
            if (take) begin
               out_d   = new_e;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (take && acc) begin
               out_d = new_e;
            end else if (take) begin
               skid_d  = new_e;
               state_d = ST_FULL;
            end else if (acc) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (acc) begin
               out_d   = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_EMPTY;
         out_q     <= '0;
         skid_q    <= '0;
         rr_last_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         out_q     <= out_d;
         skid_q    <= skid_d;
         rr_last_q <= rr_last_d;
      end
   end

   assign resp_valid    = (state_q != ST_EMPTY);
   assign resp_type     = out_q.typ;
   assign resp_req_id   = out_q.id;
   assign resp_page_idx = out_q.idx;
   assign resp_fail     = out_q.fail;
   assign resp_reason   = out_q.reason;

`ifdef MMU_RESP_STATS_EN
   logic [15:0] st_aok_q, st_afl_q, st_fok_q, st_ffl_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_aok_q <= '0;
         st_afl_q <= '0;
         st_fok_q <= '0;
         st_ffl_q <= '0;
      end else if (acc) begin
         case ({out_q.typ, out_q.fail})
            2'b00:   if (st_aok_q != 16'hFFFF) st_aok_q <= st_aok_q + 16'd1;
            2'b01:   if (st_afl_q != 16'hFFFF) st_afl_q <= st_afl_q + 16'd1;
            2'b10:   if (st_fok_q != 16'hFFFF) st_fok_q <= st_fok_q + 16'd1;
            default: if (st_ffl_q != 16'hFFFF) st_ffl_q <= st_ffl_q + 16'd1;
         endcase
      end
   end

   assign stat_alloc_ok   = st_aok_q;
   assign stat_alloc_fail = st_afl_q;
   assign stat_free_ok    = st_fok_q;
   assign stat_free_fail  = st_ffl_q;
`endif

endmodule

// File: tb/tb_mmu_resp_arbiter.sv
// tb/tb_mmu_resp_arbiter.sv - directed self-checking bench for mmu_resp_arbiter
module tb_mmu_resp_arbiter;
   localparam int ID_W   = 8;
   localparam int PIDX_W = 10;
   localparam int RSN_W  = 4;

   typedef struct {
      logic [ID_W-1:0]   id;
      logic [PIDX_W-1:0] idx;
      logic              fail;
      logic [RSN_W-1:0]  rsn;
   } ent_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              alloc_fifo_empty, alloc_fifo_pop_en, alloc_fifo_fail;
   logic [ID_W-1:0]   alloc_fifo_req_id;
   logic [PIDX_W-1:0] alloc_fifo_page_idx;
   logic [RSN_W-1:0]  alloc_fifo_reason;
   logic              free_fifo_empty, free_fifo_pop_en, free_fifo_fail;
   logic [ID_W-1:0]   free_fifo_req_id;
   logic [RSN_W-1:0]  free_fifo_reason;
   logic              resp_valid, resp_type, resp_fail;
   logic              resp_ready = 1'b0;
   logic [ID_W-1:0]   resp_req_id;
   logic [PIDX_W-1:0] resp_page_idx;
   logic [RSN_W-1:0]  resp_reason;
`ifdef MMU_RESP_STATS_EN
   logic [15:0] stat_alloc_ok, stat_alloc_fail, stat_free_ok, stat_free_fail;
`endif

   ent_t aq[$];
   ent_t fq[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   acc_cnt = 0;
   logic [7:0] e_id [4];
   logic       e_ty [4];

   mmu_resp_arbiter #(.ID_W(ID_W), .PIDX_W(PIDX_W), .RSN_W(RSN_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .alloc_fifo_empty(alloc_fifo_empty), .alloc_fifo_pop_en(alloc_fifo_pop_en),
      .alloc_fifo_req_id(alloc_fifo_req_id), .alloc_fifo_page_idx(alloc_fifo_page_idx),
      .alloc_fifo_fail(alloc_fifo_fail), .alloc_fifo_reason(alloc_fifo_reason),
      .free_fifo_empty(free_fifo_empty), .free_fifo_pop_en(free_fifo_pop_en),
      .free_fifo_req_id(free_fifo_req_id), .free_fifo_fail(free_fifo_fail),
      .free_fifo_reason(free_fifo_reason),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_type(resp_type),
      .resp_req_id(resp_req_id), .resp_page_idx(resp_page_idx),
      .resp_fail(resp_fail), .resp_reason(resp_reason)
`ifdef MMU_RESP_STATS_EN
      ,
      .stat_alloc_ok(stat_alloc_ok), .stat_alloc_fail(stat_alloc_fail),
      .stat_free_ok(stat_free_ok), .stat_free_fail(stat_free_fail)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      alloc_fifo_empty    = (aq.size() == 0);
      alloc_fifo_req_id   = (aq.size() != 0) ? aq[0].id   : '0;
      alloc_fifo_page_idx = (aq.size() != 0) ? aq[0].idx  : '0;
      alloc_fifo_fail     = (aq.size() != 0) ? aq[0].fail : 1'b0;
      alloc_fifo_reason   = (aq.size() != 0) ? aq[0].rsn  : '0;
      free_fifo_empty     = (fq.size() == 0);
      free_fifo_req_id    = (fq.size() != 0) ? fq[0].id   : '0;
      free_fifo_fail      = (fq.size() != 0) ? fq[0].fail : 1'b0;
      free_fifo_reason    = (fq.size() != 0) ? fq[0].rsn  : '0;
      #1;
   endtask

   // One clock: pops decided before the edge are applied to the FIFO models after it.
   task automatic cycle();
      logic pa, pf;
      pa = alloc_fifo_pop_en;
      pf = free_fifo_pop_en;
      if (resp_valid && resp_ready) acc_cnt++;
      @(posedge clk);
      #1;
      if (pa && aq.size() != 0) void'(aq.pop_front());
      if (pf && fq.size() != 0) void'(fq.pop_front());
      drive();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      resp_ready = 1'b0;
      aq.delete();
      fq.delete();
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      drive();
      // reset state
      #3;
      chk("rst_valid", resp_valid, 0);
      chk("rst_type", resp_type, 0);
      chk("rst_id", resp_req_id, 0);
      chk("rst_idx", resp_page_idx, 0);
      chk("rst_fail_reason", {resp_fail, resp_reason}, 0);
      chk("rst_pops", {alloc_fifo_pop_en, free_fifo_pop_en}, 0);
      do_reset();

      // single alloc
      resp_ready = 1'b1;
      aq.push_back('{id: 3, idx: 5, fail: 0, rsn: 0});
      drive();
      chk("t1_pop_c0", {alloc_fifo_pop_en, free_fifo_pop_en}, 2'b10);
      cycle();
      chk("t1_valid", resp_valid, 1);
      chk("t1_type", resp_type, 0);
      chk("t1_id", resp_req_id, 3);
      chk("t1_idx", resp_page_idx, 5);
      chk("t1_fail", resp_fail, 0);
      cycle();
      chk("t1_drained", resp_valid, 0);

      // round robin, both FIFOs with two entries
      do_reset();
      resp_ready = 1'b1;
      aq.push_back('{id: 10, idx: 20, fail: 0, rsn: 0});
      aq.push_back('{id: 11, idx: 21, fail: 0, rsn: 0});
      fq.push_back('{id: 12, idx: 0, fail: 0, rsn: 0});
      fq.push_back('{id: 13, idx: 0, fail: 0, rsn: 0});
      drive();
      e_id[0] = 10; e_id[1] = 12; e_id[2] = 11; e_id[3] = 13;
      e_ty[0] = 0;  e_ty[1] = 1;  e_ty[2] = 0;  e_ty[3] = 1;
      chk("t2_first_pop", {alloc_fifo_pop_en, free_fifo_pop_en}, 2'b10);
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk($sformatf("t2_valid%0d", i), resp_valid, 1);
         chk($sformatf("t2_type%0d", i), resp_type, e_ty[i]);
         chk($sformatf("t2_id%0d", i), resp_req_id, e_id[i]);
         chk($sformatf("t2_nodual%0d", i), alloc_fifo_pop_en & free_fifo_pop_en, 0);
      end
      cycle();
      chk("t2_drained", resp_valid, 0);

      // backpressure fills skid, then drains in order
      do_reset();
      aq.push_back('{id: 21, idx: 1, fail: 0, rsn: 0});
      aq.push_back('{id: 22, idx: 2, fail: 0, rsn: 0});
      aq.push_back('{id: 23, idx: 3, fail: 0, rsn: 0});
      drive();
      chk("t3_pop0", alloc_fifo_pop_en, 1);
      cycle();
      chk("t3_pop1", alloc_fifo_pop_en, 1);
      chk("t3_id_a", resp_req_id, 21);
      cycle();
      chk("t3_full_nopop", alloc_fifo_pop_en, 0);
      chk("t3_id_b", resp_req_id, 21);
      cycle();
      chk("t3_hold_valid", resp_valid, 1);
      chk("t3_hold_id", resp_req_id, 21);
      chk("t3_hold_nopop", alloc_fifo_pop_en, 0);
      resp_ready = 1'b1;
      #1;
      chk("t3_nopop_full_acc", alloc_fifo_pop_en, 0);
      cycle();
      chk("t3_id_c", resp_req_id, 22);
      chk("t3_pop_third", alloc_fifo_pop_en, 1);
      cycle();
      chk("t3_id_d", resp_req_id, 23);
      chk("t3_valid_d", resp_valid, 1);
      cycle();
      chk("t3_drained", resp_valid, 0);

      // free failure fields and reason masking on a successful alloc
      do_reset();
      resp_ready = 1'b1;
      fq.push_back('{id: 9, idx: 0, fail: 1, rsn: 2});
      aq.push_back('{id: 4, idx: 6, fail: 0, rsn: 7});
      drive();
      cycle();
      chk("t4_alloc_type", resp_type, 0);
      chk("t4_alloc_idx", resp_page_idx, 6);
      chk("t4_alloc_reason_masked", resp_reason, 0);
      cycle();
      chk("t4_free_type", resp_type, 1);
      chk("t4_free_id", resp_req_id, 9);
      chk("t4_free_idx", resp_page_idx, 0);
      chk("t4_free_fail", resp_fail, 1);
      chk("t4_free_reason", resp_reason, 2);

      // reset while FULL
      do_reset();
      aq.push_back('{id: 31, idx: 1, fail: 0, rsn: 0});
      aq.push_back('{id: 32, idx: 2, fail: 0, rsn: 0});
      aq.push_back('{id: 33, idx: 3, fail: 0, rsn: 0});
      drive();
      cycle();
      cycle();
      chk("t5_full_valid", resp_valid, 1);
      chk("t5_full_nopop", alloc_fifo_pop_en, 0);
      rst_n = 1'b0;
      #1;
      chk("t5_async_drop", resp_valid, 0);
      chk("t5_nopop_in_reset", alloc_fifo_pop_en, 0);
      aq.delete();
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      resp_ready = 1'b1;
      #1;
      chk("t5_post_valid", resp_valid, 0);
      chk("t5_post_pops", {alloc_fifo_pop_en, free_fifo_pop_en}, 0);
      cycle();
      chk("t5_no_stale", {resp_valid, resp_req_id}, 0);
      chk("t5_post_pops2", {alloc_fifo_pop_en, free_fifo_pop_en}, 0);

`ifdef MMU_RESP_STATS_EN
      do_reset();
      resp_ready = 1'b1;
      acc_cnt = 0;
      for (int c = 0; c < 70000 && acc_cnt < 65537; c++) begin
         if (aq.size() < 2) aq.push_back('{id: 1, idx: 1, fail: 0, rsn: 0});
         drive();
         cycle();
      end
      resp_ready = 1'b0;
      #1;
      chk("stat_accept_budget", acc_cnt, 65537);
      chk("stat_alloc_ok", stat_alloc_ok, 16'hFFFF);
      chk("stat_alloc_fail", stat_alloc_fail, 0);
      chk("stat_free_ok", stat_free_ok, 0);
      chk("stat_free_fail", stat_free_fail, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
